// File: rtl/wb_arb_pkg.sv
// Shared types for the WB / MDU register-file write arbiter.
// Holds the data width, buffer-entry layout and grant-source encoding.
package wb_arb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } buf_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_BUF,
        GNT_BYPASS
    } gnt_src_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Holding FIFO for MDU results awaiting a free register-file write slot.
// A kill port clears the valid bit of every entry whose rd matches.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [XLEN-1:0]       push_data_i,
    input  logic                  pop_i,
    input  logic                  kill_en_i,
    input  logic [REG_ADDR_W-1:0] kill_rd_i,
    output buf_entry_t            head_o,
    output logic [CW-1:0]         count_o
);

    buf_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Kill runs before push so a slot refilled this cycle keeps its new entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en_i && mem_q[i].rd == kill_rd_i) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{valid: 1'b1,
                                     rd:    push_rd_i,
                                     data:  push_data_i};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU.
// Optional WB_ARB_STATS_EN adds saturating conflict/stall counters.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int XLEN         = wb_arb_pkg::XLEN,
    parameter  int DEPTH        = 2,
    parameter  int STARVE_LIMIT = 4,
    localparam int CW           = $clog2(DEPTH) + 1,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WB_WRITE_ENABLE,
    input  logic [REG_ADDR_W-1:0] WB_RD,
    input  logic [XLEN-1:0]       WB_WRITE_DATA,
    input  logic                  MDU_VALID,
    input  logic [REG_ADDR_W-1:0] MDU_RD,
    input  logic [XLEN-1:0]       MDU_RESULT,
    output logic                  MDU_READY,
    output logic                  RF_WRITE_ENABLE,
    output logic [REG_ADDR_W-1:0] RF_RD,
    output logic [XLEN-1:0]       RF_WRITE_DATA,
    output logic                  PIPE_STALL,
    output logic [CW-1:0]         BUF_COUNT
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]           CONFLICT_COUNT,
    output logic [15:0]           STALL_COUNT
`endif
);

    logic                  pipe_req;
    logic                  buf_empty;
    logic                  mdu_acc;
    logic                  head_gnt;
    logic                  push;
    logic                  kill_en;
    gnt_src_e              gnt;
    buf_entry_t            head;
    logic [CW-1:0]         buf_cnt;

    logic                  we_d,     we_q;
    logic [REG_ADDR_W-1:0] rd_d,     rd_q;
    logic [XLEN-1:0]       data_d,   data_q;
    logic                  stall_d,  stall_q;
    logic [SW-1:0]         starve_d, starve_q;

    assign pipe_req  = WB_WRITE_ENABLE && (WB_RD != '0);
    assign buf_empty = (buf_cnt == '0);
    assign MDU_READY = !RST && (buf_cnt < CW'(DEPTH));
    assign mdu_acc   = MDU_VALID && MDU_READY;

    // During a stall the WB inputs are a replay, so they must not win.
    always_comb begin
        gnt = GNT_NONE;
        if (stall_q && !buf_empty) begin
            gnt = GNT_BUF;
        end else if (!stall_q && pipe_req) begin
            gnt = GNT_PIPE;
        end else if (!buf_empty) begin
            gnt = GNT_BUF;
        end else if (mdu_acc) begin
            gnt = GNT_BYPASS;
        end
    end

    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        unique case (gnt)
            GNT_PIPE: begin
                we_d   = 1'b1;
                rd_d   = WB_RD;
                data_d = WB_WRITE_DATA;
            end
            GNT_BUF: begin
                we_d = head.valid;
                if (head.valid) begin
                    rd_d   = head.rd;
                    data_d = head.data;
                end
            end
            GNT_BYPASS: begin
                we_d = (MDU_RD != '0);
                if (MDU_RD != '0) begin
                    rd_d   = MDU_RD;
                    data_d = MDU_RESULT;
                end
            end
            GNT_NONE: we_d = 1'b0;
        endcase
    end

    assign head_gnt = (gnt == GNT_BUF);
    assign kill_en  = (gnt == GNT_PIPE);

    // A same-cycle MDU result for the pipeline's rd is older: drop it.
    assign push = mdu_acc
               && (gnt != GNT_BYPASS)
               && (MDU_RD != '0)
               && !(kill_en && MDU_RD == WB_RD);

    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (head_gnt) begin
            starve_d = '0;
        end else if (!buf_empty) begin
            if (starve_q != SW'(STARVE_LIMIT)) begin
                starve_d = starve_q + SW'(1);
            end
            stall_d = (starve_q == SW'(STARVE_LIMIT - 1));
        end
    end

    wb_arb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .push_i     (push),
        .push_rd_i  (MDU_RD),
        .push_data_i(MDU_RESULT),
        .pop_i      (head_gnt),
        .kill_en_i  (kill_en),
        .kill_rd_i  (WB_RD),
        .head_o     (head),
        .count_o    (buf_cnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign RF_WRITE_ENABLE = we_q;
    assign RF_RD           = rd_q;
    assign RF_WRITE_DATA   = data_q;
    assign PIPE_STALL      = stall_q;
    assign BUF_COUNT       = buf_cnt;

`ifdef WB_ARB_STATS_EN
    logic [15:0] conf_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            conf_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pipe_req && !buf_empty && conf_q != 16'hFFFF) begin
                conf_q <= conf_q + 16'd1;
            end
            if (stall_q && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign CONFLICT_COUNT = conf_q;
    assign STALL_COUNT    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: cycle table plus a write scoreboard.
// Expected RF writes are queued at drive time and popped on RF_WRITE_ENABLE.
module tb_wb_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WB_WRITE_ENABLE = 1'b0;
    logic [4:0]  WB_RD = '0;
    logic [31:0] WB_WRITE_DATA = '0;
    logic        MDU_VALID = 1'b0;
    logic [4:0]  MDU_RD = '0;
    logic [31:0] MDU_RESULT = '0;
    logic        MDU_READY;
    logic        RF_WRITE_ENABLE;
    logic [4:0]  RF_RD;
    logic [31:0] RF_WRITE_DATA;
    logic        PIPE_STALL;
    logic [1:0]  BUF_COUNT;
`ifdef WB_ARB_STATS_EN
    logic [15:0] CONFLICT_COUNT;
    logic [15:0] STALL_COUNT;
`endif

    wb_write_arbiter dut (
        .CLK(CLK), .RST(RST),
        .WB_WRITE_ENABLE(WB_WRITE_ENABLE), .WB_RD(WB_RD),
        .WB_WRITE_DATA(WB_WRITE_DATA),
        .MDU_VALID(MDU_VALID), .MDU_RD(MDU_RD), .MDU_RESULT(MDU_RESULT),
        .MDU_READY(MDU_READY),
        .RF_WRITE_ENABLE(RF_WRITE_ENABLE), .RF_RD(RF_RD),
        .RF_WRITE_DATA(RF_WRITE_DATA),
        .PIPE_STALL(PIPE_STALL), .BUF_COUNT(BUF_COUNT)
`ifdef WB_ARB_STATS_EN
        , .CONFLICT_COUNT(CONFLICT_COUNT), .STALL_COUNT(STALL_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        we;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [1:0]  cnt;
        logic        stall;
        logic        rdy;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t  sb[$];
    wr_t  exp_w;
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
        input logic we, input logic [4:0] erd, input logic [31:0] edata,
        input logic [1:0] cnt, input logic stall, input logic rdy);
        vec_t v;
        v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data;
        v.mv = mv; v.mrd = mrd; v.mres = mres;
        v.we = we; v.erd = erd; v.edata = edata;
        v.cnt = cnt; v.stall = stall; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    // Writes that the DUT actually performs are matched in order here.
    always @(posedge CLK) begin
        #1;
        if (RF_WRITE_ENABLE === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got x%0d=%h, want no write",
                         RF_RD, RF_WRITE_DATA);
            end else begin
                exp_w = sb.pop_front();
                if (RF_RD !== exp_w.rd || RF_WRITE_DATA !== exp_w.data) begin
                    errors++;
                    $display("FAIL write_order: got x%0d=%h, want x%0d=%h",
                             RF_RD, RF_WRITE_DATA, exp_w.rd, exp_w.data);
                end
            end
        end
    end

    task automatic step(input vec_t v, input int idx);
        @(negedge CLK);
        WB_WRITE_ENABLE = v.wb_en;
        WB_RD           = v.wb_rd;
        WB_WRITE_DATA   = v.wb_data;
        MDU_VALID       = v.mv;
        MDU_RD          = v.mrd;
        MDU_RESULT      = v.mres;
        if (v.we) begin
            sb.push_back('{rd: v.erd, data: v.edata});
        end
        @(posedge CLK);
        #1;
        chk("rf_we", idx, 32'(RF_WRITE_ENABLE), 32'(v.we));
        chk("buf_count", idx, 32'(BUF_COUNT), 32'(v.cnt));
        chk("pipe_stall", idx, 32'(PIPE_STALL), 32'(v.stall));
        chk("mdu_ready", idx, 32'(MDU_READY), 32'(v.rdy));
    endtask

    initial begin
        // wb_en rd data | mv rd res || we rd data | cnt stall rdy
        tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 0,            1, 1, 32'hDEADBEEF, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,            1, 5, 32'hCAFEBABE, 1, 5, 32'hCAFEBABE, 0, 0, 1));
        tbl.push_back(mk(1, 2, 32'h11,       1, 3, 32'h22,       1, 2, 32'h11,       1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 3, 32'h22,       0, 0, 1));
        tbl.push_back(mk(0, 0, 0,            1, 0, 32'h123,      0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h55,       0, 0, 0,            0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(1, 10, 32'd100,     1, 6, 32'h66,       1, 10, 32'd100,     1, 0, 1));
        tbl.push_back(mk(1, 11, 32'd101,     1, 7, 32'h77,       1, 11, 32'd101,     2, 0, 0));
        tbl.push_back(mk(1, 12, 32'd102,     1, 9, 32'h99,       1, 12, 32'd102,     2, 0, 0));
        tbl.push_back(mk(1, 13, 32'd103,     1, 9, 32'h99,       1, 13, 32'd103,     2, 0, 0));
        tbl.push_back(mk(1, 14, 32'd104,     1, 9, 32'h99,       1, 14, 32'd104,     2, 1, 0));
        tbl.push_back(mk(1, 15, 32'd105,     1, 9, 32'h99,       1, 6, 32'h66,       1, 0, 1));
        tbl.push_back(mk(1, 15, 32'd105,     1, 9, 32'h99,       1, 15, 32'd105,     2, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 7, 32'h77,       1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            1, 21, 32'h2121,    1, 9, 32'h99,       1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 21, 32'h2121,    0, 0, 1));
        tbl.push_back(mk(1, 20, 32'h1,       1, 8, 32'hAAAA,     1, 20, 32'h1,       1, 0, 1));
        tbl.push_back(mk(1, 8, 32'hBBBB,     0, 0, 0,            1, 8, 32'hBBBB,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(1, 9, 32'h1234,     1, 9, 32'h5678,     1, 9, 32'h1234,     0, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 1));

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we", 0, 32'(RF_WRITE_ENABLE), 32'd0);
        chk("rst_rd", 0, 32'(RF_RD), 32'd0);
        chk("rst_data", 0, RF_WRITE_DATA, 32'd0);
        chk("rst_stall", 0, 32'(PIPE_STALL), 32'd0);
        chk("rst_count", 0, 32'(BUF_COUNT), 32'd0);
        chk("rst_ready", 0, 32'(MDU_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", 0, 32'(MDU_READY), 32'd1);

        foreach (tbl[i]) step(tbl[i], i);

        // Fill the buffer, then reset: the buffered results must vanish.
        step(mk(1, 1, 32'h1, 1, 6, 32'h6, 1, 1, 32'h1, 1, 0, 1), 100);
        step(mk(1, 2, 32'h2, 1, 7, 32'h7, 1, 2, 32'h2, 2, 0, 0), 101);
        @(negedge CLK);
        RST             = 1'b1;
        WB_WRITE_ENABLE = 1'b0;
        MDU_VALID       = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_rst_we", 1, 32'(RF_WRITE_ENABLE), 32'd0);
        chk("mid_rst_rd", 1, 32'(RF_RD), 32'd0);
        chk("mid_rst_data", 1, RF_WRITE_DATA, 32'd0);
        chk("mid_rst_stall", 1, 32'(PIPE_STALL), 32'd0);
        chk("mid_rst_count", 1, 32'(BUF_COUNT), 32'd0);
        chk("mid_rst_ready", 1, 32'(MDU_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 200 + k);
        end

        @(negedge CLK);
        chk("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
